// File: rtl/video_line_packer_if.sv
// video_line_packer_if: raw pixel stream in and packed 128-bit word stream out.
interface video_line_packer_if;
  logic         vsync_in;
  logic         de_in;
  logic [15:0]  data_in;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_sof;
  logic         out_eol;
  logic         out_eof;
  modport master (
    input  vsync_in, de_in, data_in,
    output out_valid, out_data, out_sof, out_eol, out_eof
  );
  modport slave (
    output vsync_in, de_in, data_in,
    input  out_valid, out_data, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/video_line_packer.sv
// video_line_packer: frame-aligned capture of RGB565 pixels packed 8 per 128-bit word,
// every line padded to H_ACTIVE/8 words so frames land at fixed word offsets.
module video_line_packer #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  video_line_packer_if.master        vif,
  output logic                       line_err,
  output logic                       frame_err,
  output logic [9:0]                 line_cnt
);
  localparam int WPL = H_ACTIVE / 8;
  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int WW = $clog2(WPL + 1);
  localparam logic [PW-1:0] H_W = PW'(H_ACTIVE);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [WW-1:0] WPL_W = WW'(WPL);
  localparam logic [WW-1:0] W_LAST = WW'(WPL - 1);
  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);
  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DONE} state_t;
  state_t state, state_nx;
  logic vs_q, de_q, pad, drop;
  logic [PW-1:0] pix_cnt;
  logic [WW-1:0] word_cnt;
  logic [127:0] lane_buf;
  logic de, de_rise, de_fall, vs_rise, vs_fall, act, start, enter, vs_abort;
  logic line_end, pad_now, pad_emit, line_done, store, over, last_lane, emit, err_rise;
  logic sof_c, eol_c, last_line;
  always_comb begin
    de = vif.de_in & ~vif.vsync_in;
    de_rise = de & ~de_q;
    de_fall = ~de & de_q;
    vs_rise = vif.vsync_in & ~vs_q;
    vs_fall = ~vif.vsync_in & vs_q;
    start = enable & (state == IDLE);
    enter = enable & (state == WAIT_VS) & vs_fall;
    vs_abort = enable & (state == ACTIVE) & vs_rise;
    act = enable & (state == ACTIVE) & ~vs_rise;
    line_end = act & de_fall & ~drop;
    pad_now = act & (pad | line_end);
    pad_emit = pad_now & (word_cnt < WPL_W);
    line_done = pad_now & (word_cnt == WPL_W);
    store = act & de & ~pad & ~drop & (pix_cnt < H_W);
    over = act & de & ~pad & ~drop & ~(pix_cnt < H_W);
    err_rise = act & pad & de_rise;
    last_lane = store & (pix_cnt[2:0] == 3'd7);
    emit = pad_emit | last_lane;
    last_line = line_cnt == V_LAST;
    sof_c = (line_cnt == 10'd0) & (word_cnt == '0);
    eol_c = word_cnt == W_LAST;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = WAIT_VS;
      WAIT_VS: state_nx = vs_fall ? ACTIVE : WAIT_VS;
      ACTIVE:  state_nx = vs_rise ? WAIT_VS : (line_done & last_line) ? DONE : ACTIVE;
      DONE:    state_nx = vif.vsync_in ? WAIT_VS : DONE;
      default: state_nx = IDLE;
    endcase
    if (!enable) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
      pad <= 1'b0;
      drop <= 1'b0;
      pix_cnt <= '0;
      word_cnt <= '0;
      lane_buf <= '0;
      line_cnt <= '0;
      line_err <= 1'b0;
      frame_err <= 1'b0;
      vif.out_valid <= 1'b0;
      vif.out_data <= '0;
      vif.out_sof <= 1'b0;
      vif.out_eol <= 1'b0;
      vif.out_eof <= 1'b0;
    end else begin
      vs_q <= vif.vsync_in;
      de_q <= de;
      vif.out_valid <= emit;
      vif.out_sof <= emit & sof_c;
      vif.out_eol <= emit & eol_c;
      vif.out_eof <= emit & eol_c & last_line;
      if (emit) vif.out_data <= last_lane ? {vif.data_in, lane_buf[111:0]} : lane_buf;
      if (start) begin
        line_err <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        if (over | err_rise | (line_end & (pix_cnt < H_W))) line_err <= 1'b1;
        if (vs_abort) frame_err <= 1'b1;
      end
      // outside ACTIVE the partial line is discarded; a line already under way at frame start is skipped
      if (!act) begin
        pix_cnt <= '0;
        word_cnt <= '0;
        lane_buf <= '0;
        pad <= 1'b0;
        drop <= enter & de;
        if (!enable | enter) line_cnt <= '0;
      end else begin
        if (store) pix_cnt <= pix_cnt + P_ONE;
        if (emit) begin
          word_cnt <= word_cnt + W_ONE;
          lane_buf <= '0;
        end else if (store) lane_buf[{pix_cnt[2:0], 4'b0} +: 16] <= vif.data_in;
        pad <= (pad | line_end) & ~line_done;
        drop <= de & (drop | err_rise);
        if (line_done) begin
          pix_cnt <= '0;
          word_cnt <= '0;
          line_cnt <= line_cnt + 10'd1;
        end
      end
    end
endmodule

// File: tb/tb_video_line_packer.sv
// tb_video_line_packer: frame table plus corner sequences, word scoreboard checked at negedge.
module tb_video_line_packer;
  localparam int H = 16;
  localparam int V = 3;
  localparam int WPL = H / 8;
  typedef struct packed {
    logic [127:0] d;
    logic sof, eol, eof;
  } word_t;
  typedef struct {
    bit reen;
    int nl;
    int n0, n1, n2;
    bit le;
    bit fe;
    int lc;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic line_err, frame_err;
  logic [9:0] line_cnt;
  int errors = 0;
  int checks = 0;
  int nwords = 0;
  word_t exp_q[$];
  video_line_packer_if vif();
  video_line_packer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vif(vif),
    .line_err(line_err), .frame_err(frame_err), .line_cnt(line_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && vif.out_valid) begin
    word_t e;
    nwords++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_word: got data=%h sof=%b eol=%b eof=%b, required no word",
               vif.out_data, vif.out_sof, vif.out_eol, vif.out_eof);
    end else begin
      e = exp_q.pop_front();
      if ({vif.out_data, vif.out_sof, vif.out_eol, vif.out_eof} !== e) begin
        errors++;
        $display("FAIL word: got data=%h sof=%b eol=%b eof=%b, required data=%h sof=%b eol=%b eof=%b",
                 vif.out_data, vif.out_sof, vif.out_eol, vif.out_eof, e.d, e.sof, e.eol, e.eof);
      end
    end
  end
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask
  task automatic tick(input logic vs, input logic d, input logic [15:0] x);
    vif.vsync_in = vs;
    vif.de_in = d;
    vif.data_in = x;
    @(posedge clk);
    #1;
  endtask
  task automatic push_line(input int n, input int base, input int li);
    word_t w;
    for (int k = 0; k < WPL; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++)
        if (k * 8 + j < n && k * 8 + j < H) w.d[j*16 +: 16] = 16'(base + k * 8 + j);
      w.sof = (li == 0) && (k == 0);
      w.eol = (k == WPL - 1);
      w.eof = w.eol && (li == V - 1);
      exp_q.push_back(w);
    end
  endtask
  task automatic drive_pix(input int n, input int base);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 16'(base + i));
  endtask
  task automatic send_line(input int n, input int base, input int li);
    push_line(n, base, li);
    drive_pix(n, base);
    repeat (8) tick(1'b0, 1'b0, 16'h0);
  endtask
  task automatic pulse_vs();
    repeat (2) tick(1'b1, 1'b0, 16'h0);
    repeat (2) tick(1'b0, 1'b0, 16'h0);
  endtask
  task automatic restart();
    enable = 1'b0;
    tick(1'b0, 1'b0, 16'h0);
    enable = 1'b1;
    tick(1'b0, 1'b0, 16'h0);
  endtask
  vec_t tv[7];
  initial begin
    int w0;
    tv[0] = '{1, 3, 16, 16, 16, 0, 0, 3};
    tv[1] = '{1, 3, 11, 16, 16, 1, 0, 3};
    tv[2] = '{1, 3, 3, 16, 16, 1, 0, 3};
    tv[3] = '{1, 3, 16, 20, 16, 1, 0, 3};
    tv[4] = '{1, 2, 16, 16, 16, 0, 0, 2};
    tv[5] = '{0, 3, 16, 16, 16, 0, 1, 3};
    tv[6] = '{1, 3, 16, 16, 16, 0, 0, 3};
    vif.vsync_in = 1'b0;
    vif.de_in = 1'b0;
    vif.data_in = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 128'(vif.out_valid), 128'd0);
    chk("rst_out_data", vif.out_data, 128'd0);
    chk("rst_markers", 128'({vif.out_sof, vif.out_eol, vif.out_eof}), 128'd0);
    chk("rst_line_err", 128'(line_err), 128'd0);
    chk("rst_frame_err", 128'(frame_err), 128'd0);
    chk("rst_line_cnt", 128'(line_cnt), 128'd0);
    for (int v = 0; v < 7; v++) begin
      if (tv[v].reen) restart();
      pulse_vs();
      for (int l = 0; l < tv[v].nl; l++)
        send_line(l == 0 ? tv[v].n0 : l == 1 ? tv[v].n1 : tv[v].n2, v * 256 + l * 32, l);
      chk($sformatf("v%0d_line_err", v), 128'(line_err), 128'(tv[v].le));
      chk($sformatf("v%0d_frame_err", v), 128'(frame_err), 128'(tv[v].fe));
      chk($sformatf("v%0d_line_cnt", v), 128'(line_cnt), 128'(tv[v].lc));
      chk($sformatf("v%0d_words_left", v), 128'(exp_q.size()), 128'd0);
    end
    // next line starts while the short line is still being padded
    restart();
    pulse_vs();
    push_line(3, 16'h0a00, 0);
    drive_pix(3, 16'h0a00);
    tick(1'b0, 1'b0, 16'h0);
    drive_pix(16, 16'h0b00);
    repeat (8) tick(1'b0, 1'b0, 16'h0);
    chk("pad_hit_line_err", 128'(line_err), 128'd1);
    chk("pad_hit_line_cnt", 128'(line_cnt), 128'd1);
    chk("pad_hit_words_left", 128'(exp_q.size()), 128'd0);
    restart();
    pulse_vs();
    drive_pix(5, 16'h0c00);
    enable = 1'b0;
    tick(1'b0, 1'b1, 16'h0c05);
    tick(1'b0, 1'b1, 16'h0c06);
    enable = 1'b1;
    w0 = nwords;
    drive_pix(16, 16'h0d00);
    repeat (8) tick(1'b0, 1'b0, 16'h0);
    chk("en_drop_no_words", 128'(nwords), 128'(w0));
    chk("en_drop_line_cnt", 128'(line_cnt), 128'd0);
    pulse_vs();
    send_line(16, 16'h0e00, 0);
    chk("en_drop_resume_words_left", 128'(exp_q.size()), 128'd0);
    restart();
    pulse_vs();
    send_line(3, 16'h0f00, 0);
    drive_pix(5, 16'h1000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(vif.out_valid), 128'd0);
    chk("arst_out_data", vif.out_data, 128'd0);
    chk("arst_line_err", 128'(line_err), 128'd0);
    chk("arst_line_cnt", 128'(line_cnt), 128'd0);
    #1 rst_n = 1'b1;
    w0 = nwords;
    drive_pix(16, 16'h1100);
    repeat (8) tick(1'b0, 1'b0, 16'h0);
    chk("arst_idle_no_words", 128'(nwords), 128'(w0));
    chk("final_words_left", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
